// File: rtl/ula_multiciclo.sv
// Registered MIPS execute-stage ALU: single-cycle logic/arithmetic ops plus
// iterative unsigned multiply (shift-add) and divide (restoring) into HI/LO.
module ula_multiciclo #(
  parameter int LARGURA      = 32,
  parameter int LARGURA_CONT = 6
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inicio,
  input  logic [3:0]         opCode,
  input  logic [LARGURA-1:0] operador1,
  input  logic [LARGURA-1:0] operador2,
  output logic [LARGURA-1:0] resultado,
  output logic [LARGURA-1:0] hi,
  output logic [LARGURA-1:0] lo,
  output logic               isZero,
  output logic               overflow,
  output logic               erroDiv,
  output logic               ocupado,
  output logic               pronto
);

  typedef enum logic [1:0] {OCIOSO, CALCULA, CONCLUI} estado_t;

  localparam int MSB = LARGURA - 1;

  estado_t estado, prox;

  logic [LARGURA_CONT-1:0] cont;
  logic [LARGURA-1:0]      work_hi;
  logic [LARGURA-1:0]      work_lo;
  logic [LARGURA-1:0]      operando;
  logic                    eh_div;

  logic                    aceita;
  logic                    op_longa;
  logic                    ultima;

  logic [LARGURA-1:0]      soma;
  logic [LARGURA-1:0]      dif;
  logic [LARGURA-1:0]      res_simples;
  logic                    ovf_simples;

  logic [LARGURA:0]        mult_soma;
  logic [2*LARGURA-1:0]    mult_prox;
  logic [LARGURA:0]        div_tmp;
  logic                    div_ge;
  logic [LARGURA-1:0]      div_dif;
  logic [LARGURA-1:0]      div_rem;
  logic [LARGURA-1:0]      div_q;

  assign ocupado  = (estado != OCIOSO);
  assign aceita   = inicio && (estado == OCIOSO);
  assign op_longa = (opCode == 4'b1000) || (opCode == 4'b1001);
  assign ultima   = (cont == LARGURA_CONT'(LARGURA - 1));

  assign soma = operador1 + operador2;
  assign dif  = operador1 - operador2;

  always_comb begin
    res_simples = '0;
    ovf_simples = 1'b0;
    case (opCode)
      4'b0000: res_simples = operador1 & operador2;
      4'b0001: res_simples = operador1 | operador2;
      4'b0010: begin
        res_simples = soma;
        ovf_simples = (operador1[MSB] == operador2[MSB]) && (soma[MSB] != operador1[MSB]);
      end
      4'b0110: begin
        res_simples = dif;
        ovf_simples = (operador1[MSB] != operador2[MSB]) && (dif[MSB] != operador1[MSB]);
      end
      4'b0111: res_simples = ($signed(operador1) < $signed(operador2)) ? LARGURA'(1) : '0;
      default: res_simples = '0;
    endcase
  end

  // Multiply: {work_hi, work_lo} is the product accumulator, multiplier in the low half.
  assign mult_soma = {1'b0, work_hi} + {1'b0, operando};
  assign mult_prox = work_lo[0] ? {mult_soma, work_lo[LARGURA-1:1]}
                                : {1'b0, work_hi, work_lo[LARGURA-1:1]};

  // Divide: work_hi is the partial remainder, work_lo shifts dividend out and
  // quotient in. A zero divisor naturally yields quotient all-ones, remainder = dividend.
  assign div_tmp = {work_hi, work_lo[LARGURA-1]};
  assign div_ge  = (div_tmp >= {1'b0, operando});
  assign div_dif = div_tmp[LARGURA-1:0] - operando;
  assign div_rem = div_ge ? div_dif : div_tmp[LARGURA-1:0];
  assign div_q   = {work_lo[LARGURA-2:0], div_ge};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (aceita && op_longa) prox = CALCULA;
      CALCULA: if (ultima) prox = CONCLUI;
      CONCLUI: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resultado <= '0;
      hi        <= '0;
      lo        <= '0;
      isZero    <= 1'b1;
      overflow  <= 1'b0;
      erroDiv   <= 1'b0;
      pronto    <= 1'b0;
      cont      <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      operando  <= '0;
      eh_div    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            erroDiv <= 1'b0;
            if (op_longa) begin
              work_hi  <= '0;
              work_lo  <= operador1;
              operando <= operador2;
              eh_div   <= opCode[0];
              cont     <= '0;
              overflow <= 1'b0;
            end else begin
              resultado <= res_simples;
              isZero    <= (res_simples == '0);
              overflow  <= ovf_simples;
              pronto    <= 1'b1;
            end
          end
        end
        CALCULA: begin
          cont <= cont + 1'b1;
          if (eh_div) {work_hi, work_lo} <= {div_rem, div_q};
          else        {work_hi, work_lo} <= mult_prox;
        end
        CONCLUI: begin
          hi        <= work_hi;
          lo        <= work_lo;
          resultado <= work_lo;
          isZero    <= (work_lo == '0);
          erroDiv   <= eh_div && (operando == '0);
          pronto    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo at LARGURA=32 and LARGURA=8.
module tb_ula_multiciclo;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        inicio;
  logic [3:0]  opCode;
  logic [31:0] operador1, operador2;
  logic [31:0] resultado, hi, lo;
  logic        isZero, overflow, erroDiv, ocupado, pronto;

  logic        inicio8;
  logic [3:0]  opCode8;
  logic [7:0]  a8, b8;
  logic [7:0]  resultado8, hi8, lo8;
  logic        isZero8, overflow8, erroDiv8, ocupado8, pronto8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ula_multiciclo #(.LARGURA(32), .LARGURA_CONT(6)) dut (
    .clock(clk), .reset_n(reset_n), .inicio(inicio), .opCode(opCode),
    .operador1(operador1), .operador2(operador2), .resultado(resultado),
    .hi(hi), .lo(lo), .isZero(isZero), .overflow(overflow), .erroDiv(erroDiv),
    .ocupado(ocupado), .pronto(pronto)
  );

  ula_multiciclo #(.LARGURA(8), .LARGURA_CONT(4)) dut8 (
    .clock(clk), .reset_n(reset_n), .inicio(inicio8), .opCode(opCode8),
    .operador1(a8), .operador2(b8), .resultado(resultado8),
    .hi(hi8), .lo(lo8), .isZero(isZero8), .overflow(overflow8), .erroDiv(erroDiv8),
    .ocupado(ocupado8), .pronto(pronto8)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        z, ovf;
  } vetor_t;

  task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nome, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the sampling edge.
  task automatic go32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    inicio = 1'b1; opCode = op; operador1 = a; operador2 = b;
    @(posedge clk); #1;
    inicio = 1'b0;
  endtask

  task automatic go8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    inicio8 = 1'b1; opCode8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    inicio8 = 1'b0;
  endtask

  // Counts edges after the sampling edge until pronto; optionally pulses an
  // add request on the 32-bit DUT at edge 'inj' while it is busy.
  task automatic espera(input bit w8, input int inj, output int lat, output int ocup);
    lat = 0; ocup = 0;
    while (!(w8 ? pronto8 : pronto) && lat < 100) begin
      if (w8 ? ocupado8 : ocupado) ocup++;
      @(posedge clk); #1;
      lat++;
      if (lat == inj) begin
        inicio = 1'b1; opCode = 4'b0010; operador1 = 32'd1; operador2 = 32'd2;
      end else if (lat == inj + 1) begin
        inicio = 1'b0;
      end
    end
  endtask

  vetor_t tab[10];
  int lat, ocup, npr;

  initial begin
    tab[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    tab[1] = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    tab[2] = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    tab[3] = '{4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
    tab[4] = '{4'b0001, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1'b0};
    tab[5] = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    tab[6] = '{4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    tab[7] = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
    tab[8] = '{4'b0010, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0};
    tab[9] = '{4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0};

    reset_n = 1'b0;
    inicio = 1'b0; opCode = '0; operador1 = '0; operador2 = '0;
    inicio8 = 1'b0; opCode8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resultado", resultado, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_isZero", isZero, 1);
    chk("rst_flags", {overflow, erroDiv, ocupado, pronto}, 0);
    chk("rst8_isZero", {isZero8, resultado8}, 9'h100);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      go32(tab[i].op, tab[i].a, tab[i].b);
      chk($sformatf("v%0d_pronto", i), {pronto, ocupado}, 2'b10);
      chk($sformatf("v%0d_res", i), resultado, tab[i].res);
      chk($sformatf("v%0d_z", i), isZero, tab[i].z);
      chk($sformatf("v%0d_ovf", i), overflow, tab[i].ovf);
      chk($sformatf("v%0d_hilo", i), {hi, lo}, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", i), pronto, 0);
    end

    // Full-range multiply: latency and busy window.
    go32(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    espera(1'b0, -1, lat, ocup);
    chk("mul_lat", lat, 33);
    chk("mul_ocup", ocup, 33);
    chk("mul_hi", hi, 32'hFFFFFFFE);
    chk("mul_lo", lo, 32'h00000001);
    chk("mul_res", {resultado, isZero, overflow, erroDiv}, {32'h1, 3'b000});
    @(posedge clk); #1;
    chk("mul_pulse", {pronto, ocupado}, 0);

    // Request during busy is ignored; request in pronto cycle is accepted.
    go32(4'b1000, 32'h12345678, 32'h00000010);
    espera(1'b0, 5, lat, ocup);
    chk("busy_lat", lat, 33);
    chk("busy_hilo", {hi, lo}, {32'h1, 32'h23456780});
    go32(4'b0010, 32'd1, 32'd2);
    chk("b2b_res", {pronto, resultado}, {1'b1, 32'd3});
    chk("b2b_hilo", {hi, lo}, {32'h1, 32'h23456780});

    go32(4'b1001, 32'd100, 32'd7);
    espera(1'b0, -1, lat, ocup);
    chk("div_lat", lat, 33);
    chk("div_hilo", {hi, lo}, {32'd2, 32'd14});
    chk("div_res", {resultado, erroDiv}, {32'd14, 1'b0});

    go32(4'b1001, 32'd100, 32'd0);
    espera(1'b0, -1, lat, ocup);
    chk("div0_lat", lat, 33);
    chk("div0_hilo", {hi, lo}, {32'd100, 32'hFFFFFFFF});
    chk("div0_flags", {resultado, isZero, erroDiv}, {32'hFFFFFFFF, 1'b0, 1'b1});

    go32(4'b0010, 32'd2, 32'd2);
    chk("clr_err", {resultado, erroDiv}, {32'd4, 1'b0});
    chk("clr_hilo", {hi, lo}, {32'd100, 32'hFFFFFFFF});

    go32(4'b0010, 32'h7FFFFFFF, 32'd1);
    go32(4'b0101, 32'd9, 32'd9);
    chk("rsv_out", {pronto, resultado, isZero, overflow, erroDiv}, {1'b1, 32'd0, 3'b100});
    chk("rsv_hilo", {hi, lo}, {32'd100, 32'hFFFFFFFF});

    // Asynchronous reset while idle.
    #2 reset_n = 1'b0;
    #1;
    chk("rsti_out", {resultado, hi, lo}, 0);
    chk("rsti_flags", {isZero, overflow, erroDiv, ocupado, pronto}, 5'b10000);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset five cycles into a multiply: aborted, no pronto afterwards.
    go32(4'b1000, 32'd3, 32'd5);
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("rstm_out", {resultado, hi, lo, isZero, ocupado, pronto}, {96'd0, 3'b100});
    @(posedge clk); #1 reset_n = 1'b1;
    npr = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pronto) npr++;
    end
    chk("rstm_nopronto", npr, 0);
    go32(4'b1000, 32'd3, 32'd5);
    espera(1'b0, -1, lat, ocup);
    chk("rstm_next", {hi, lo, 32'(lat)}, {32'd0, 32'd15, 32'd33});

    // LARGURA=8 instance.
    go8(4'b1000, 8'd15, 8'd17);
    espera(1'b1, -1, lat, ocup);
    chk("m8_lat", lat, 9);
    chk("m8_ocup", ocup, 9);
    chk("m8_hilo", {hi8, lo8, resultado8}, {8'h00, 8'hFF, 8'hFF});
    go8(4'b0101, 8'd3, 8'd4);
    chk("rsv8", {pronto8, resultado8, isZero8, overflow8, erroDiv8}, {1'b1, 8'd0, 3'b100});
    go8(4'b0010, 8'h7F, 8'h01);
    chk("add8_ovf", {resultado8, overflow8, ocupado8}, {8'h80, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Parametrised, registered successor of the MIPS datapath ALU. Adds signed overflow and divide-by-zero flags to the single-cycle logic and arithmetic ops. Adds iterative unsigned multiply and divide with a start/done handshake, writing results to HI/LO. Sits in the execute stage; control holds the stage while ocupado=1.

Parameters:
LARGURA, 32, operand/result width in bits (>=4)
LARGURA_CONT, 6, iteration counter width; must satisfy 2^LARGURA_CONT > LARGURA

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
inicio  in  1  start strobe; operands/opCode sampled on the edge where inicio=1 and ocupado=0
opCode  in  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt (signed), 1000 multu, 1001 divu; others reserved
operador1  in  LARGURA  left operand
operador2  in  LARGURA  right operand
resultado  out  LARGURA  result of single-cycle ops; equals lo after multu/divu
hi  out  LARGURA  multu: upper product half; divu: remainder
lo  out  LARGURA  multu: lower product half; divu: quotient
isZero  out  1  1 when resultado==0 (registered together with resultado)
overflow  out  1  signed overflow on add/sub; 0 for all other ops
erroDiv  out  1  divu with operador2==0
ocupado  out  1  operation in progress; new inicio ignored
pronto  out  1  one-cycle pulse: outputs valid

Behaviour:
- Reset (reset_n=0, asynchronous): state OCIOSO. resultado, hi, lo, overflow, erroDiv, ocupado, pronto = 0. isZero=1, consistent with resultado=0. Internal counter and working registers cleared. Reset during CALCULA aborts the operation; no pronto is issued.
- States: OCIOSO, CALCULA, CONCLUI.
- OCIOSO + inicio, single-cycle op: result registered on the same edge; pronto=1 for the following cycle; stay in OCIOSO; ocupado stays 0. Latency is 1 cycle.
- OCIOSO + inicio, multu/divu: latch operands; counter=0; ocupado=1; go to CALCULA.
- CALCULA: one bit per cycle.
  - multu: shift-add over a 2*LARGURA accumulator.
  - divu: restoring division.
  - After LARGURA iterations, go to CONCLUI.
- CONCLUI: write hi/lo; resultado=lo; set isZero; pronto=1 for 1 cycle; ocupado=0; return to OCIOSO.
- multu/divu latency: pronto is high LARGURA+1 cycles after the sampling edge. ocupado is high for exactly LARGURA+1 cycles.
- inicio while ocupado=1: ignored, with no effect on the current operation.
- inicio with a reserved opCode: resultado=0, isZero=1, flags=0, pronto pulses, hi/lo unchanged.
- Arithmetic:
  - add/sub are modulo 2^LARGURA.
  - overflow = signed overflow of the operation, i.e. operand signs agree (add) or differ (sub) and the result sign differs from operador1.
  - slt: resultado = {0...,1} if operador1 < operador2 as signed, else 0; overflow=0.
- Single-cycle ops leave hi/lo unchanged. multu/divu clear overflow.
- divu with operador2==0: takes the normal full latency. Result: lo = all ones, hi = operador1, erroDiv=1.
- erroDiv is cleared by the next accepted operation.
- Outputs hold their values between operations. pronto is the only pulsed output.
- Back-to-back: inicio may be asserted in the same cycle that pronto is high. It is accepted if ocupado=0.

Test Plan:
- Reset mid-op: reset_n=0 asserted while idle and again 5 cycles into multu -> all outputs 0, isZero=1, no pronto afterwards, next op works normally.
- Single-cycle ops, LARGURA=32: add 0x7FFFFFFF+1 -> resultado 0x80000000, overflow=1, pronto after 1 cycle. sub 5-5 -> 0, isZero=1. slt -1,1 -> 1. and 0xF0F0,0xFF00 -> 0xF000.
- multu, LARGURA=32: 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001. pronto exactly 33 cycles after the sampling edge; ocupado high for 33 cycles.
- divu 100/7 -> lo 14, hi 2, erroDiv=0. divu 100/0 -> lo 0xFFFFFFFF, hi 100, erroDiv=1. The next add clears erroDiv.
- Busy and back-to-back: inicio pulses mid-multu with add operands -> ignored, multu result correct. add issued in the pronto cycle -> accepted, result one cycle later.
- Parameter sweep, LARGURA=8, LARGURA_CONT=4: multu 15*17 -> hi 0x00, lo 0xFF, latency 9. Reserved opCode 0101 -> resultado 0, pronto pulses.
